// File: rtl/calc_display_pkg.sv
// Shared display constants, FSM state encoding and digit formatting for the result path.
// Latency: n/a (declarations and a pure combinational helper).
// Backpressure: n/a.
package calc_display_pkg;

  localparam logic [3:0] DIGIT_MINUS = 4'hA;
  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  localparam int DISP_MAX_POS = 9999;
  localparam int DISP_MIN_NEG = -999;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FORMAT} state_t;

  // Turn a 4-nibble BCD magnitude into display codes: blank leading zeros
  // above digit1 and put the minus sign just left of the leading numeral.
  function automatic logic [15:0] format_digits(input logic [15:0] bcd,
                                                input logic        neg,
                                                input logic        ovf);
    logic [15:0] out;
    int          msd;
    out = bcd;
    msd = 0;
    if (ovf) begin
      out = {4{DIGIT_MINUS}};
    end else begin
      for (int i = 1; i < 4; i++) begin
        if (bcd[4*i +: 4] != 4'd0) msd = i;
      end
      for (int j = 1; j < 4; j++) begin
        if (j > msd) begin
          out[4*j +: 4] = (neg && (j == msd + 1)) ? DIGIT_MINUS : DIGIT_BLANK;
        end
      end
    end
    return out;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble corrector: adds 3 to a BCD nibble of 5 or more.
// Latency: combinational.
// Backpressure: none.
// Ports: nib_i - BCD nibble before the shift; nib_o - corrected nibble.
module bcd_add3 (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  always_comb begin
    nib_o = (nib_i >= 4'd5) ? (nib_i + 4'd3) : nib_i;
  end

endmodule

// File: rtl/result_to_digits.sv
// Signed binary result to four seven-segment digit codes via double-dabble.
// Latency: WIDTH+2 cycles from accepted start to updated digits; one conversion per WIDTH+3 cycles.
// Backpressure: start is only sampled in IDLE; starts while busy are dropped, not queued.
// Ports: clk/reset (async, active-high); start/value request; digit1 (right) .. digit4 (left)
//        held display codes; busy while converting; done one-cycle pulse; overflow level.
module result_to_digits
  import calc_display_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  output logic [3:0]       digit1,
  output logic [3:0]       digit2,
  output logic [3:0]       digit3,
  output logic [3:0]       digit4,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam int               CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    CNT_LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [WIDTH-1:0] MAG_ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] POS_LIMIT = WIDTH'(DISP_MAX_POS);
  localparam logic [WIDTH-1:0] NEG_LIMIT = WIDTH'(-DISP_MIN_NEG);
  localparam logic [15:0]      DISP_RST  = {DIGIT_BLANK, DIGIT_BLANK, DIGIT_BLANK, 4'd0};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH-1:0] mag_q, mag_d, mag_abs;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      bcd_q, bcd_d, bcd_adj;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [15:0]      disp_q, disp_d;
  logic             done_q, done_d;
  logic             overflow_q, overflow_d;

  for (genvar g = 0; g < 4; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nib_i (bcd_q[4*g +: 4]),
      .nib_o (bcd_adj[4*g +: 4])
    );
  end

  // Two's-complement magnitude; the most negative input maps to 2^(WIDTH-1) unsigned.
  assign mag_abs = value_q[WIDTH-1] ? (~value_q + MAG_ONE) : value_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_LAST) state_d = FORMAT;
      FORMAT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_comb begin
    value_d    = value_q;
    mag_d      = mag_q;
    neg_d      = neg_q;
    ovf_d      = ovf_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    disp_d     = disp_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) value_d = value;
      end
      LOAD: begin
        neg_d = value_q[WIDTH-1];
        mag_d = mag_abs;
        ovf_d = value_q[WIDTH-1] ? (mag_abs > NEG_LIMIT) : (mag_abs > POS_LIMIT);
        bcd_d = '0;
        cnt_d = '0;
      end
      SHIFT: begin
        // Bits carried out of the top BCD nibble only exist for out-of-range results.
        bcd_d = (bcd_adj << 1) | {15'd0, mag_q[WIDTH-1]};
        mag_d = mag_q << 1;
        cnt_d = cnt_q + CNT_ONE;
      end
      FORMAT: begin
        disp_d     = format_digits(bcd_q, neg_q, ovf_q);
        overflow_d = ovf_q;
        done_d     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q    <= '0;
      mag_q      <= '0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      disp_q     <= DISP_RST;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      value_q    <= value_d;
      mag_q      <= mag_d;
      neg_q      <= neg_d;
      ovf_q      <= ovf_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      disp_q     <= disp_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  // Output logic
  always_comb begin
    busy     = (state_q != IDLE);
    done     = done_q;
    overflow = overflow_q;
    digit1   = disp_q[3:0];
    digit2   = disp_q[7:4];
    digit3   = disp_q[11:8];
    digit4   = disp_q[15:12];
  end

endmodule

// File: tb/tb_result_to_digits.sv
module tb_result_to_digits;

  localparam int W = 16;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] value;
  logic [3:0]   digit1, digit2, digit3, digit4;
  logic         busy, done, overflow;

  int           checks;
  int           errors;
  logic [15:0]  shown;

  result_to_digits #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .value    (value),
    .digit1   (digit1),
    .digit2   (digit2),
    .digit3   (digit3),
    .digit4   (digit4),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] disp();
    return {digit4, digit3, digit2, digit1};
  endfunction

  function automatic bit model_ovf(input int v);
    return (v > 9999) || (v < -999);
  endfunction

  // Write the decimal string right-aligned, then the sign, over a blank field.
  function automatic logic [15:0] model_digits(input int v);
    logic [3:0] d [4];
    int         mag;
    int         p;
    for (int i = 0; i < 4; i++) d[i] = 4'hF;
    if (model_ovf(v)) begin
      for (int i = 0; i < 4; i++) d[i] = 4'hA;
    end else begin
      mag = (v < 0) ? -v : v;
      p   = 0;
      do begin
        d[p] = 4'(mag % 10);
        mag  = mag / 10;
        p++;
      end while (mag > 0);
      if (v < 0) d[p] = 4'hA;
    end
    return {d[3], d[2], d[1], d[0]};
  endfunction

  // Called just after a falling edge. pre: start/value already driven by the
  // previous call (start in its done cycle). ign_a/ign_b: cycles to pulse a
  // stray start. chain: leave start asserted for v_next in the done cycle.
  task automatic convert(input int v, input bit pre, input int ign_a, input int ign_b,
                         input bit chain, input int v_next);
    int          cyc;
    int          busy_cnt;
    int          hold_bad;
    bit          seen;
    logic [15:0] exp_d;
    exp_d = model_digits(v);
    if (!pre) begin
      start = 1'b1;
      value = 16'(v);
    end
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    cyc      = 1;
    busy_cnt = 0;
    hold_bad = 0;
    seen     = 1'b0;
    while (cyc < 60) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      if (disp() !== shown) hold_bad++;
      start = (cyc == ign_a) || (cyc == ign_b);
      if (start) value = 16'(-7);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    check("busy_cycles", busy_cnt, W + 2);
    check("digits_held", hold_bad, 0);
    check("digits", 32'(disp()), 32'(exp_d));
    check("overflow", 32'(overflow), 32'(model_ovf(v)));
    check("busy_low_at_done", 32'(busy), 32'd0);
    shown = exp_d;
    if (chain) begin
      start = 1'b1;
      value = 16'(v_next);
    end else begin
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
    end
  endtask

  initial begin
    int dir_vals [9];
    int v;
    int r;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    start  = 1'b0;
    value  = '0;
    shown  = 16'hFFF0;

    repeat (2) @(negedge clk);
    check("rst_digits", 32'(disp()), 32'h0000FFF0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_digits", 32'(disp()), 32'h0000FFF0);
    check("idle_busy", 32'(busy), 32'd0);

    dir_vals = '{1234, -7, -999, 0, 50, 10000, 9998, -1, 1000};
    foreach (dir_vals[i]) convert(dir_vals[i], 1'b0, 0, 0, 1'b0, 0);

    // Reset mid-conversion, with overflow set from a prior result.
    convert(10000, 1'b0, 0, 0, 1'b0, 0);
    start = 1'b1;
    value = 16'(5678);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_digits", 32'(disp()), 32'h0000FFF0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_discarded", 32'(busy), 32'd0);
    shown = 16'hFFF0;

    convert(-1000, 1'b0, 0, 0, 1'b0, 0);
    convert(-32768, 1'b0, 0, 0, 1'b0, 0);
    convert(9999, 1'b0, 0, 0, 1'b0, 0);

    // Stray starts during a conversion are dropped.
    convert(4321, 1'b0, 3, 17, 1'b0, 0);
    repeat (4) begin
      @(negedge clk);
      check("no_queued_start", 32'(busy), 32'd0);
    end

    // Start in the done cycle is accepted; digits hold until its own done.
    convert(-42, 1'b0, 0, 0, 1'b1, 777);
    convert(777, 1'b1, 0, 0, 1'b0, 0);

    for (int k = 0; k < 24; k++) begin
      r = $urandom_range(0, 3);
      if (r == 0)      v = int'($urandom_range(0, 65535)) - 32768;
      else if (r == 1) v = int'($urandom_range(0, 1998)) - 999;
      else if (r == 2) v = int'($urandom_range(0, 9999));
      else             v = int'($urandom_range(0, 20)) + 9990 - ((k % 2) * 11000);
      convert(v, 1'b0, 0, 0, 1'b0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
